// File: rtl/display_pkg.sv
// Types and constants shared between the display multiplexer and its users.
package display_pkg;

  typedef enum logic [1:0] {
    R_BLANK = 2'd0,
    R_ON    = 2'd1,
    L_BLANK = 2'd2,
    L_ON    = 2'd3
  } state_t;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_RIGHT = 2'b10;
  localparam logic [1:0] AN_LEFT  = 2'b01;

endpackage

// File: rtl/digit_shift_reg.sv
// Two-digit entry register: new keys shift in from the right.
// Also tracks how many digits have been entered, saturating at two.
module digit_shift_reg
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] new_digit,
  input  logic       digit_valid,
  input  logic       clear,
  output logic [3:0] left,
  output logic [3:0] right,
  output logic [1:0] count
);

  // clear takes priority over a simultaneous key strobe
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      left  <= 4'h0;
      right <= 4'h0;
      count <= 2'd0;
    end else if (digit_valid) begin
      left  <= right;
      right <= new_digit;
      if (count != 2'd2)
        count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexes two hex digits onto one shared segment nibble with
// active-low anode enables and a dead time before each digit is lit.
module display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 24000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] new_digit,
  input  logic       digit_valid,
  input  logic       clear,
  output logic [3:0] s,
  output logic [1:0] an,
  output logic [7:0] digits
);

  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] ON_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

  logic [3:0]    left;
  logic [3:0]    right;
  logic [1:0]    count;
  state_t        state;
  logic [CW-1:0] cnt;

  digit_shift_reg u_dig (
    .clk         (clk),
    .reset       (reset),
    .new_digit   (new_digit),
    .digit_valid (digit_valid),
    .clear       (clear),
    .left        (left),
    .right       (right),
    .count       (count)
  );

  // Refresh sequencer: the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= R_BLANK;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        R_BLANK: if (cnt == DEAD_LAST) begin state <= R_ON;    cnt <= '0; end
        R_ON:    if (cnt == ON_LAST)   begin state <= L_BLANK; cnt <= '0; end
        L_BLANK: if (cnt == DEAD_LAST) begin state <= L_ON;    cnt <= '0; end
        L_ON:    if (cnt == ON_LAST)   begin state <= R_BLANK; cnt <= '0; end
        default: begin state <= R_BLANK; cnt <= '0; end
      endcase
    end
  end

  // The left digit stays dark until two keys have been entered.
  always_comb begin
    s  = right;
    an = AN_OFF;
    case (state)
      R_ON:    an = AN_RIGHT;
      L_BLANK: s  = left;
      L_ON: begin
        s = left;
        if (count == 2'd2)
          an = AN_LEFT;
      end
      default: ;
    endcase
  end

  assign digits = {left, right};

endmodule

// File: tb/tb_display_mux.sv
// Randomised and directed bench for display_mux against a phase-based model.
module tb_display_mux;

  localparam int RD  = 8;
  localparam int DC  = 2;
  localparam int PER = 2 * (DC + RD);

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] new_digit;
  logic       digit_valid;
  logic       clear;
  logic [3:0] s;
  logic [1:0] an;
  logic [7:0] digits;

  int checks = 0;
  int errors = 0;

  // Reference: time since reset release, entered-digit history.
  int         t = 0;
  logic [3:0] m_l = 4'h0;
  logic [3:0] m_r = 4'h0;
  int         m_cnt = 0;

  display_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (reset),
    .new_digit   (new_digit),
    .digit_valid (digit_valid),
    .clear       (clear),
    .s           (s),
    .an          (an),
    .digits      (digits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst_n, input logic dv, input logic [3:0] d, input logic clr);
    int   ph;
    logic rside;
    logic lit;
    logic [1:0] e_an;
    reset = rst_n; digit_valid = dv; new_digit = d; clear = clr;
    @(posedge clk);
    if (!rst_n) begin
      t = 0; m_l = 4'h0; m_r = 4'h0; m_cnt = 0;
    end else begin
      t++;
      if (clr) begin
        m_l = 4'h0; m_r = 4'h0; m_cnt = 0;
      end else if (dv) begin
        m_l = m_r; m_r = d;
        if (m_cnt < 2) m_cnt++;
      end
    end
    #1;
    ph    = t % PER;
    rside = (ph < DC + RD);
    lit   = (ph >= DC && ph < DC + RD) || (ph >= 2*DC + RD && m_cnt == 2);
    e_an  = !lit ? 2'b11 : (rside ? 2'b10 : 2'b01);
    chk("s",      {4'h0, s},  {4'h0, rside ? m_r : m_l});
    chk("an",     {6'h0, an}, {6'h0, e_an});
    chk("digits", digits,     {m_l, m_r});
    chk("count",  {6'h0, dut.u_dig.count}, 8'(m_cnt));
    chk("an_both_low", {7'h0, an == 2'b00}, 8'h00);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; digit_valid = 1'b0; new_digit = 4'h0; clear = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 1'b1);
    chk("reset_an", {6'h0, an}, 8'h03);
    chk("reset_digits", digits, 8'h00);

    idle(25);

    cyc(1'b1, 1'b1, 4'h3, 1'b0);
    cyc(1'b1, 1'b1, 4'h7, 1'b0);
    idle(45);
    chk("entered_37", digits, 8'h37);

    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b1, 1'b1, 4'h5, 1'b0);
    idle(3 * PER);
    chk("single_05", digits, 8'h05);

    cyc(1'b1, 1'b1, 4'h3, 1'b0);
    cyc(1'b1, 1'b1, 4'h7, 1'b0);
    cyc(1'b1, 1'b1, 4'h9, 1'b1);
    chk("clear_wins", digits, 8'h00);
    chk("clear_count", {6'h0, dut.u_dig.count}, 8'h00);

    cyc(1'b1, 1'b1, 4'h3, 1'b0);
    cyc(1'b1, 1'b1, 4'h7, 1'b0);
    cyc(1'b1, 1'b1, 4'hA, 1'b0);
    idle(PER + 5);
    chk("shift_7A", digits, 8'h7A);

    // Reach L_ON, then pulse reset for one cycle.
    for (int i = 0; i < PER && (t % PER) < 2*DC + RD + 2; i++) idle(1);
    cyc(1'b0, 1'b1, 4'h1, 1'b0);
    chk("midon_reset_an", {6'h0, an}, 8'h03);
    chk("midon_reset_digits", digits, 8'h00);
    idle(PER + 3);

    for (int i = 0; i < 800; i++) begin
      logic rn, dv, cl;
      rn = ($urandom_range(0, 99) != 0);
      dv = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 29) == 0);
      cyc(rn, dv, 4'($urandom_range(0, 15)), cl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
